z_writeback: RTL and testbench

Z_WRITEBACK -- requirements
Module: z_writeback

---
 rtl/zwb_pkg.sv | 55 +++++
 rtl/z_writeback_if.sv | 34 +++
 rtl/zwb_decode.sv | 26 ++
 rtl/z_writeback.sv | 191 +++++++++++++++++++
 tb/tb_z_writeback.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/zwb_pkg.sv
// ---------------------------------------------------------------------------
// zwb_pkg -- shared definitions for the z_writeback block.
//   * ALU opcode constants that matter to write-back classification
//   * wb_sel target encodings
//   * capture class enum and FSM state enum
// No ports (package).
// ---------------------------------------------------------------------------
package zwb_pkg;

    // Address-producing opcodes (result goes to MAR)
    localparam logic [4:0] OP_LD     = 5'b00000;
    localparam logic [4:0] OP_A01    = 5'b00001;
    localparam logic [4:0] OP_A02    = 5'b00010;
    localparam logic [4:0] OP_A13    = 5'b10011;

    // Single-result opcodes (result[31:0] goes to a GPR)
    localparam logic [4:0] OP_ADD    = 5'b00011;
    localparam logic [4:0] OP_S04    = 5'b00100;
    localparam logic [4:0] OP_S05    = 5'b00101;
    localparam logic [4:0] OP_S06    = 5'b00110;
    localparam logic [4:0] OP_S07    = 5'b00111;
    localparam logic [4:0] OP_S08    = 5'b01000;
    localparam logic [4:0] OP_S09    = 5'b01001;
    localparam logic [4:0] OP_S0A    = 5'b01010;
    localparam logic [4:0] OP_S0B    = 5'b01011;
    localparam logic [4:0] OP_S0C    = 5'b01100;
    localparam logic [4:0] OP_S0D    = 5'b01101;
    localparam logic [4:0] OP_S0E    = 5'b01110;
    localparam logic [4:0] OP_S11    = 5'b10001;
    localparam logic [4:0] OP_S12    = 5'b10010;

    // Pair-result opcodes (LO then HI)
    localparam logic [4:0] OP_MUL    = 5'b01111;
    localparam logic [4:0] OP_DIV    = 5'b10000;

    // wb_sel encodings
    localparam logic [1:0] WB_SEL_GPR = 2'b00;
    localparam logic [1:0] WB_SEL_LO  = 2'b01;
    localparam logic [1:0] WB_SEL_HI  = 2'b10;
    localparam logic [1:0] WB_SEL_MAR = 2'b11;

    typedef enum logic [1:0] {
        CLS_SINGLE = 2'd0,
        CLS_PAIR   = 2'd1,
        CLS_ADDR   = 2'd2,
        CLS_DROP   = 2'd3
    } zwb_class_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } zwb_state_e;

endpackage : zwb_pkg

// File: rtl/z_writeback_if.sv
// ---------------------------------------------------------------------------
// z_writeback_if -- bundles the ALU capture channel and the write-back beat
// channel of z_writeback.
//   ALU side : alu_valid, alu_ready, alu_result[63:0], alu_opcode[4:0],
//              alu_dest[3:0]
//   WB side  : wb_valid, wb_ready, wb_sel[1:0], wb_addr[3:0], wb_data[31:0]
// Modports: slave  = the write-back block itself,
//           master = the environment (ALU producer + register-file consumer).
// ---------------------------------------------------------------------------
interface z_writeback_if;

    logic        alu_valid;
    logic        alu_ready;
    logic [63:0] alu_result;
    logic [4:0]  alu_opcode;
    logic [3:0]  alu_dest;

    logic        wb_valid;
    logic        wb_ready;
    logic [1:0]  wb_sel;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    modport slave (
        input  alu_valid, alu_result, alu_opcode, alu_dest, wb_ready,
        output alu_ready, wb_valid, wb_sel, wb_addr, wb_data
    );

    modport master (
        output alu_valid, alu_result, alu_opcode, alu_dest, wb_ready,
        input  alu_ready, wb_valid, wb_sel, wb_addr, wb_data
    );

endinterface : z_writeback_if

// File: rtl/zwb_decode.sv
// ---------------------------------------------------------------------------
// zwb_decode -- purely combinational opcode-to-class decoder.
//   i_opcode [4:0]  ALU opcode
//   o_class         SINGLE / PAIR / ADDR / DROP
// ---------------------------------------------------------------------------
module zwb_decode
    import zwb_pkg::*;
(
    input  logic [4:0] i_opcode,
    output zwb_class_e o_class
);

    // Classify the opcode; anything not listed is dropped.
    always_comb begin
        o_class = CLS_DROP;
        case (i_opcode)
            OP_ADD, OP_S04, OP_S05, OP_S06, OP_S07,
            OP_S08, OP_S09, OP_S0A, OP_S0B, OP_S0C,
            OP_S0D, OP_S0E, OP_S11, OP_S12:      o_class = CLS_SINGLE;
            OP_MUL, OP_DIV:                      o_class = CLS_PAIR;
            OP_LD, OP_A01, OP_A02, OP_A13:       o_class = CLS_ADDR;
            default:                             o_class = CLS_DROP;
        endcase
    end

endmodule : zwb_decode

// File: rtl/z_writeback.sv
// ---------------------------------------------------------------------------
// z_writeback -- captures one ALU result and emits it as one or two
// write-back beats (GPR, MAR, or LO followed by HI).
//   i_clock      rising-edge clock
//   i_clear      asynchronous active-low reset
//   bus          z_writeback_if.slave (ALU capture + write-back beat)
//   o_zero_flag  (only with ZWB_FLAGS_EN) zero flag of last SINGLE/PAIR
//   o_neg_flag   (only with ZWB_FLAGS_EN) sign flag of last SINGLE/PAIR
// Optional feature macro: ZWB_FLAGS_EN.
// All write-back outputs are registered; alu_ready is a decode of the
// state register, so it is glitch-free and asserted only in IDLE.
// ---------------------------------------------------------------------------
module z_writeback
    import zwb_pkg::*;
(
    input  logic           i_clock,
    input  logic           i_clear,
    z_writeback_if.slave   bus
`ifdef ZWB_FLAGS_EN
    ,
    output logic           o_zero_flag,
    output logic           o_neg_flag
`endif
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_BEAT0 = ST_BEAT0;
    localparam logic [1:0] S_BEAT1 = ST_BEAT1;

    logic [1:0]  r_state;
    logic        r_pair;       // captured result needs a HI beat
    logic [31:0] r_hi;         // HI half kept for the second beat
    logic        r_wb_valid;
    logic [1:0]  r_wb_sel;
    logic [3:0]  r_wb_addr;
    logic [31:0] r_wb_data;

    logic [1:0]  w_state_nx;
    logic        w_pair_nx;
    logic [31:0] w_hi_nx;
    logic        w_valid_nx;
    logic [1:0]  w_sel_nx;
    logic [3:0]  w_addr_nx;
    logic [31:0] w_data_nx;

    zwb_class_e  w_class;
    logic        w_capture;
    logic        w_beat_done;

    zwb_decode u_decode (
        .i_opcode (bus.alu_opcode),
        .o_class  (w_class)
    );

    assign w_capture   = bus.alu_valid & (r_state == S_IDLE);
    assign w_beat_done = r_wb_valid & bus.wb_ready;

    // Next-state and next-beat computation; payload held unless a beat completes.
    always_comb begin
        w_state_nx = r_state;
        w_pair_nx  = r_pair;
        w_hi_nx    = r_hi;
        w_valid_nx = r_wb_valid;
        w_sel_nx   = r_wb_sel;
        w_addr_nx  = r_wb_addr;
        w_data_nx  = r_wb_data;
        case (r_state)
            S_IDLE: begin
                if (w_capture && (w_class != CLS_DROP)) begin
                    w_state_nx = S_BEAT0;
                    w_valid_nx = 1'b1;
                    w_data_nx  = bus.alu_result[31:0];
                    w_pair_nx  = 1'b0;
                    w_hi_nx    = 32'd0;
                    w_addr_nx  = 4'd0;
                    case (w_class)
                        CLS_SINGLE: begin
                            w_sel_nx  = WB_SEL_GPR;
                            w_addr_nx = bus.alu_dest;
                        end
                        CLS_PAIR: begin
                            w_sel_nx  = WB_SEL_LO;
                            w_pair_nx = 1'b1;
                            w_hi_nx   = bus.alu_result[63:32];
                        end
                        CLS_ADDR: begin
                            w_sel_nx  = WB_SEL_MAR;
                        end
                        default: begin
                            w_sel_nx  = WB_SEL_GPR;
                        end
                    endcase
                end else begin
                    // DROP or no capture: stay idle with a quiet bus
                    w_state_nx = S_IDLE;
                end
            end
            S_BEAT0: begin
                if (w_beat_done && r_pair) begin
                    w_state_nx = S_BEAT1;
                    w_sel_nx   = WB_SEL_HI;
                    w_addr_nx  = 4'd0;
                    w_data_nx  = r_hi;
                end else if (w_beat_done) begin
                    w_state_nx = S_IDLE;
                    w_valid_nx = 1'b0;
                    w_sel_nx   = 2'd0;
                    w_addr_nx  = 4'd0;
                    w_data_nx  = 32'd0;
                end else begin
                    w_state_nx = S_BEAT0;
                end
            end
            S_BEAT1: begin
                if (w_beat_done) begin
                    w_state_nx = S_IDLE;
                    w_pair_nx  = 1'b0;
                    w_hi_nx    = 32'd0;
                    w_valid_nx = 1'b0;
                    w_sel_nx   = 2'd0;
                    w_addr_nx  = 4'd0;
                    w_data_nx  = 32'd0;
                end else begin
                    w_state_nx = S_BEAT1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_pair_nx  = 1'b0;
                w_hi_nx    = 32'd0;
                w_valid_nx = 1'b0;
                w_sel_nx   = 2'd0;
                w_addr_nx  = 4'd0;
                w_data_nx  = 32'd0;
            end
        endcase
    end

    // State and registered write-back outputs; reset discards any pending beat.
    always_ff @(posedge i_clock or negedge i_clear) begin
        if (!i_clear) begin
            r_state    <= S_IDLE;
            r_pair     <= 1'b0;
            r_hi       <= 32'd0;
            r_wb_valid <= 1'b0;
            r_wb_sel   <= 2'd0;
            r_wb_addr  <= 4'd0;
            r_wb_data  <= 32'd0;
        end else begin
            r_state    <= w_state_nx;
            r_pair     <= w_pair_nx;
            r_hi       <= w_hi_nx;
            r_wb_valid <= w_valid_nx;
            r_wb_sel   <= w_sel_nx;
            r_wb_addr  <= w_addr_nx;
            r_wb_data  <= w_data_nx;
        end
    end

    assign bus.alu_ready = (r_state == S_IDLE);
    assign bus.wb_valid  = r_wb_valid;
    assign bus.wb_sel    = r_wb_sel;
    assign bus.wb_addr   = r_wb_addr;
    assign bus.wb_data   = r_wb_data;

`ifdef ZWB_FLAGS_EN
    logic r_zero_flag;
    logic r_neg_flag;

    // Flags follow SINGLE/PAIR captures only; ADDR and DROP leave them alone.
    always_ff @(posedge i_clock or negedge i_clear) begin
        if (!i_clear) begin
            r_zero_flag <= 1'b0;
            r_neg_flag  <= 1'b0;
        end else if (w_capture && (w_class == CLS_SINGLE)) begin
            r_zero_flag <= (bus.alu_result[31:0] == 32'd0);
            r_neg_flag  <= bus.alu_result[31];
        end else if (w_capture && (w_class == CLS_PAIR)) begin
            r_zero_flag <= (bus.alu_result == 64'd0);
            r_neg_flag  <= bus.alu_result[63];
        end else begin
            r_zero_flag <= r_zero_flag;
            r_neg_flag  <= r_neg_flag;
        end
    end

    assign o_zero_flag = r_zero_flag;
    assign o_neg_flag  = r_neg_flag;
`endif

endmodule : z_writeback

// File: tb/tb_z_writeback.sv
// ---------------------------------------------------------------------------
// tb_z_writeback -- directed, table-driven bench for z_writeback.
// Flag checks are compiled in only when ZWB_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_z_writeback;
    import zwb_pkg::*;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    z_writeback_if bus();

`ifdef ZWB_FLAGS_EN
    logic zf;
    logic nf;
`endif

    z_writeback dut (
        .i_clock (clk),
        .i_clear (clr),
        .bus     (bus)
`ifdef ZWB_FLAGS_EN
        ,
        .o_zero_flag (zf),
        .o_neg_flag  (nf)
`endif
    );

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]  op;
        logic [63:0] res;
        logic [3:0]  dest;
        logic        has_beat;
        logic        pair;
        logic [1:0]  sel;
        logic [3:0]  addr;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_chk(input string name, input logic [1:0] sel,
                            input logic [3:0] addr, input logic [31:0] data);
        chk({name, ".valid"}, {63'd0, bus.wb_valid}, 64'd1);
        chk({name, ".sel"},   {62'd0, bus.wb_sel},   {62'd0, sel});
        chk({name, ".addr"},  {60'd0, bus.wb_addr},  {60'd0, addr});
        chk({name, ".data"},  {32'd0, bus.wb_data},  {32'd0, data});
        chk({name, ".rdy"},   {63'd0, bus.alu_ready}, 64'd0);
    endtask

    task automatic idle_chk(input string name);
        chk({name, ".valid"}, {63'd0, bus.wb_valid}, 64'd0);
        chk({name, ".sel"},   {62'd0, bus.wb_sel},   64'd0);
        chk({name, ".addr"},  {60'd0, bus.wb_addr},  64'd0);
        chk({name, ".data"},  {32'd0, bus.wb_data},  64'd0);
        chk({name, ".rdy"},   {63'd0, bus.alu_ready}, 64'd1);
    endtask

    task automatic drive(input logic [4:0] op, input logic [63:0] res, input logic [3:0] dest);
        bus.alu_valid  = 1'b1;
        bus.alu_opcode = op;
        bus.alu_result = res;
        bus.alu_dest   = dest;
    endtask

    initial begin
        //          op        result                   dest  beat pair sel    addr  lo             hi
        vt[0]  = '{5'b00011, 64'h0000_0000_0000_0005, 4'd3,  1'b1, 1'b0, 2'b00, 4'd3,  32'h0000_0005, 32'h0};
        vt[1]  = '{5'b01111, 64'h0000_0001_FFFF_FFFE, 4'd7,  1'b1, 1'b1, 2'b01, 4'd0,  32'hFFFF_FFFE, 32'h0000_0001};
        vt[2]  = '{5'b00000, 64'h0000_0000_0000_0064, 4'd5,  1'b1, 1'b0, 2'b11, 4'd0,  32'h0000_0064, 32'h0};
        vt[3]  = '{5'b11111, 64'h0000_0000_0000_AAAA, 4'd4,  1'b0, 1'b0, 2'b00, 4'd0,  32'h0,          32'h0};
        vt[4]  = '{5'b10000, 64'hDEAD_BEEF_1234_5678, 4'd2,  1'b1, 1'b1, 2'b01, 4'd0,  32'h1234_5678, 32'hDEAD_BEEF};
        vt[5]  = '{5'b10011, 64'hFFFF_FFFF_0000_1000, 4'd9,  1'b1, 1'b0, 2'b11, 4'd0,  32'h0000_1000, 32'h0};
        vt[6]  = '{5'b10010, 64'h1234_5678_9ABC_DEF0, 4'd15, 1'b1, 1'b0, 2'b00, 4'd15, 32'h9ABC_DEF0, 32'h0};
        vt[7]  = '{5'b10100, 64'h0000_0000_0000_0001, 4'd1,  1'b0, 1'b0, 2'b00, 4'd0,  32'h0,          32'h0};
        vt[8]  = '{5'b01110, 64'h0000_0000_0000_0000, 4'd11, 1'b1, 1'b0, 2'b00, 4'd11, 32'h0,          32'h0};
        vt[9]  = '{5'b00001, 64'h0000_0000_CAFE_F00D, 4'd6,  1'b1, 1'b0, 2'b11, 4'd0,  32'hCAFE_F00D, 32'h0};
        vt[10] = '{5'b10001, 64'h0000_0000_8000_0001, 4'd12, 1'b1, 1'b0, 2'b00, 4'd12, 32'h8000_0001, 32'h0};
        vt[11] = '{5'b00111, 64'h5555_5555_0000_0042, 4'd8,  1'b1, 1'b0, 2'b00, 4'd8,  32'h0000_0042, 32'h0};

        // Reset state
        clr            = 1'b0;
        bus.alu_valid  = 1'b0;
        bus.alu_opcode = 5'd0;
        bus.alu_result = 64'd0;
        bus.alu_dest   = 4'd0;
        bus.wb_ready   = 1'b0;
        #12;
        idle_chk("reset");
`ifdef ZWB_FLAGS_EN
        chk("reset.zf", {63'd0, zf}, 64'd0);
        chk("reset.nf", {63'd0, nf}, 64'd0);
`endif
        clr = 1'b1;
        step();
        idle_chk("post_reset");

        // Table-driven vectors, consumer always ready
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("v%0d.pre_rdy", i), {63'd0, bus.alu_ready}, 64'd1);
            drive(vt[i].op, vt[i].res, vt[i].dest);
            step();
            bus.alu_valid = 1'b0;
            if (vt[i].has_beat) begin
                beat_chk($sformatf("v%0d.b0", i), vt[i].sel, vt[i].addr, vt[i].lo);
                step();
                if (vt[i].pair) begin
                    beat_chk($sformatf("v%0d.b1", i), WB_SEL_HI, 4'd0, vt[i].hi);
                    step();
                end
            end
            idle_chk($sformatf("v%0d.end", i));
        end

        // div with a 3-cycle stall in BEAT0; a new alu_valid during the stall is ignored
        drive(OP_DIV, 64'h0000_00A5_0000_005A, 4'd1);
        step();
        bus.wb_ready = 1'b0;
        drive(OP_ADD, 64'h0000_0000_0000_0077, 4'd8);
        for (int k = 0; k < 4; k++) begin
            beat_chk($sformatf("stall%0d", k), WB_SEL_LO, 4'd0, 32'h0000_005A);
            if (k == 3) bus.wb_ready = 1'b1;
            step();
        end
        bus.alu_valid = 1'b0;
        beat_chk("stall.hi", WB_SEL_HI, 4'd0, 32'h0000_00A5);
        step();
        idle_chk("stall.end");
        step();
        idle_chk("stall.nobeat");

        // clear pulsed during the HI beat of mul
        drive(OP_MUL, 64'h0000_0002_0000_0003, 4'd0);
        step();
        bus.alu_valid = 1'b0;
        beat_chk("clr.lo", WB_SEL_LO, 4'd0, 32'h0000_0003);
        step();
        beat_chk("clr.hi", WB_SEL_HI, 4'd0, 32'h0000_0002);
        bus.wb_ready = 1'b0;
        clr = 1'b0;
        #1;
        idle_chk("clr.async");
        #2;
        clr = 1'b1;
        bus.wb_ready = 1'b1;
        step();
        idle_chk("clr.after1");
        step();
        idle_chk("clr.after2");

`ifdef ZWB_FLAGS_EN
        // sub with zero result, then a negative single, then an ADDR that must not touch flags
        drive(OP_S04, 64'h0000_0000_0000_0000, 4'd2);
        step();
        bus.alu_valid = 1'b0;
        chk("flag.sub.zf", {63'd0, zf}, 64'd1);
        chk("flag.sub.nf", {63'd0, nf}, 64'd0);
        step();
        drive(OP_S05, 64'h0000_0000_8000_0000, 4'd2);
        step();
        bus.alu_valid = 1'b0;
        chk("flag.neg.zf", {63'd0, zf}, 64'd0);
        chk("flag.neg.nf", {63'd0, nf}, 64'd1);
        step();
        drive(OP_LD, 64'h0000_0000_0000_0000, 4'd0);
        step();
        bus.alu_valid = 1'b0;
        chk("flag.ld.zf", {63'd0, zf}, 64'd0);
        chk("flag.ld.nf", {63'd0, nf}, 64'd1);
        step();
        drive(OP_MUL, 64'h8000_0000_0000_0000, 4'd0);
        step();
        bus.alu_valid = 1'b0;
        chk("flag.mul.zf", {63'd0, zf}, 64'd0);
        chk("flag.mul.nf", {63'd0, nf}, 64'd1);
        step();
        step();
        drive(OP_DIV, 64'h0000_0000_0000_0000, 4'd0);
        step();
        bus.alu_valid = 1'b0;
        chk("flag.div.zf", {63'd0, zf}, 64'd1);
        chk("flag.div.nf", {63'd0, nf}, 64'd0);
        step();
        step();
        idle_chk("flag.end");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_z_writeback
